tow_round_ctrl: RTL and testbench



---
 rtl/tow_pkg.sv | 26 ++
 rtl/tow_lfsr.sv | 19 +
 rtl/tow_round_ctrl.sv | 161 ++++++++++++++++
 tb/tb_tow_round_ctrl.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tow_pkg.sv
// Shared definitions for the Tug-of-War game: FSM encodings, LFSR taps and
// the terminal score patterns.
package tow_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DELAY  = 3'd1,
    ST_LIGHTS = 3'd2,
    ST_SCORE  = 3'd3,
    ST_HOLD   = 3'd4,
    ST_DONE   = 3'd5
  } state_t;

  // Fibonacci feedback taps 8,6,5,4 (bit 7,5,4,3)
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  // Score display patterns that end the game
  localparam logic [6:0] SCORE_WL = 7'b1110000;
  localparam logic [6:0] SCORE_WR = 7'b0000111;

  // True when the scorer has reached a winning position
  function automatic logic is_final_score(input logic [6:0] score);
    return (score == SCORE_WL) || (score == SCORE_WR);
  endfunction

endpackage

// File: rtl/tow_lfsr.sv
// 8-bit Fibonacci LFSR used as the random source for light delay and
// fake-round selection. Advances every cycle outside reset.
module tow_lfsr
  import tow_pkg::*;
#(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  output logic [7:0] lfsr
);

  // Shift left, feeding the XOR of the tapped bits into bit 0
  always_ff @(posedge clk) begin
    if (rst) lfsr <= SEED;
    else     lfsr <= {lfsr[6:0], ^(lfsr & LFSR_TAPS)};
  end

endmodule

// File: rtl/tow_round_ctrl.sv
// Round sequencer for Tug-of-War: arms a round, waits a random delay, lights
// the start lamps, resolves the first push into a one-cycle winrnd event with
// its qualifiers, then holds off before the next round.
module tow_round_ctrl
  import tow_pkg::*;
#(
  parameter int         MIN_DELAY     = 16,
  parameter int         RAND_W        = 6,
  parameter int         LIGHT_TIMEOUT = 200,
  parameter int         HOLDOFF       = 32,
  parameter int         FAKE_EN       = 1,
  parameter logic [7:0] SEED          = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pb_l,
  input  logic       pb_r,
  input  logic       game_over,
  output logic       winrnd,
  output logic       right,
  output logic       tie,
  output logic       leds_on,
  output logic       fake,
  output logic [2:0] state_dbg
);

  localparam int DLY_MAX = MIN_DELAY + (1 << RAND_W);
  localparam int DLY_W   = (DLY_MAX > 2) ? $clog2(DLY_MAX) : 1;
  localparam int TO_W    = (LIGHT_TIMEOUT > 1) ? $clog2(LIGHT_TIMEOUT) : 1;
  localparam int HO_W    = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(LIGHT_TIMEOUT - 1);
  localparam logic [HO_W-1:0] HO_LAST = HO_W'(HOLDOFF - 1);

  state_t           state;
  logic [7:0]       lfsr;
  logic             pb_l_d, pb_r_d;
  logic             push_l, push_r, push_any;
  logic             res_right, res_tie;
  logic [DLY_W-1:0] dly;
  logic [DLY_W-1:0] dly_load;
  logic [TO_W-1:0]  tcnt;
  logic [HO_W-1:0]  hcnt;
  logic             fake_arm;

  tow_lfsr #(.SEED(SEED)) u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .lfsr (lfsr)
  );

  assign push_l    = pb_l & ~pb_l_d;
  assign push_r    = pb_r & ~pb_r_d;
  assign push_any  = push_l | push_r;
  // A simultaneous push is a tie and never credits the right player
  assign res_right = push_r & ~push_l;
  assign res_tie   = push_l & push_r;
  assign dly_load  = DLY_W'(MIN_DELAY) + DLY_W'(lfsr[RAND_W-1:0]);
  assign fake_arm  = (FAKE_EN != 0) && (lfsr[7:6] == 2'b00);
  assign state_dbg = state;

  // Previous button levels for rising-edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      pb_l_d <= 1'b0;
      pb_r_d <= 1'b0;
    end else begin
      pb_l_d <= pb_l;
      pb_r_d <= pb_r;
    end
  end

  // Round FSM with registered outputs; winrnd is high only in SCORE
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      winrnd  <= 1'b0;
      right   <= 1'b0;
      tie     <= 1'b0;
      leds_on <= 1'b0;
      fake    <= 1'b0;
      dly     <= '0;
      tcnt    <= '0;
      hcnt    <= '0;
    end else begin
      winrnd <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (game_over) begin
            state <= ST_DONE;
            right <= 1'b0;
            tie   <= 1'b0;
          end else if (!pb_l && !pb_r) begin
            // Arm only once both buttons are released
            dly   <= dly_load;
            fake  <= fake_arm;
            state <= ST_DELAY;
          end
        end
        ST_DELAY: begin
          if (push_any) begin
            // Jumped the light: lamps stay dark in SCORE
            state  <= ST_SCORE;
            winrnd <= 1'b1;
            right  <= res_right;
            tie    <= res_tie;
          end else if (dly <= DLY_W'(1)) begin
            state   <= ST_LIGHTS;
            leds_on <= 1'b1;
            tcnt    <= '0;
          end else begin
            dly <= dly - DLY_W'(1);
          end
        end
        ST_LIGHTS: begin
          if (push_any) begin
            state  <= ST_SCORE;
            winrnd <= 1'b1;
            right  <= res_right;
            tie    <= res_tie;
          end else if (tcnt == TO_LAST) begin
            // Nobody pushed: void the round as a tie
            state  <= ST_SCORE;
            winrnd <= 1'b1;
            right  <= 1'b0;
            tie    <= 1'b1;
          end else begin
            tcnt <= tcnt + TO_W'(1);
          end
        end
        ST_SCORE: begin
          state   <= ST_HOLD;
          leds_on <= 1'b0;
          hcnt    <= '0;
        end
        ST_HOLD: begin
          if (hcnt == HO_LAST) begin
            fake <= 1'b0;
            if (game_over) begin
              state <= ST_DONE;
              right <= 1'b0;
              tie   <= 1'b0;
            end else begin
              state <= ST_IDLE;
            end
          end else begin
            hcnt <= hcnt + HO_W'(1);
          end
        end
        ST_DONE: begin
          right   <= 1'b0;
          tie     <= 1'b0;
          leds_on <= 1'b0;
          fake    <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tow_round_ctrl.sv
// Bench for tow_round_ctrl: table of rounds plus hand-written sequences for
// timeout/fake, held button, mid-round reset and game over.
module tb_tow_round_ctrl;

  localparam int         MIN_D = 4;
  localparam logic [7:0] SEED  = 8'h25;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pb_l = 1'b0;
  logic       pb_r = 1'b0;
  logic       game_over = 1'b0;
  logic       winrnd, right, tie, leds_on, fake;
  logic [2:0] state_dbg;

  int n_chk = 0;
  int n_err = 0;

  tow_round_ctrl #(
    .MIN_DELAY     (MIN_D),
    .RAND_W        (1),
    .LIGHT_TIMEOUT (200),
    .HOLDOFF       (32),
    .FAKE_EN       (1),
    .SEED          (SEED)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .pb_l      (pb_l),
    .pb_r      (pb_r),
    .game_over (game_over),
    .winrnd    (winrnd),
    .right     (right),
    .tie       (tie),
    .leds_on   (leds_on),
    .fake      (fake),
    .state_dbg (state_dbg)
  );

  always #5 clk = ~clk;

  // Independent LFSR model: x^8 + x^6 + x^5 + x^4 feedback
  logic [7:0] lf_m, lf_prev;
  always @(posedge clk) begin
    lf_prev <= lf_m;
    if (rst) lf_m <= SEED;
    else     lf_m <= {lf_m[6:0], lf_m[7] ^ lf_m[5] ^ lf_m[4] ^ lf_m[3]};
  end

  // Scoreboard of expected round results
  typedef struct {
    logic r;
    logic t;
    logic l;
    logic f;
  } exp_t;
  exp_t sb[$];

  logic winrnd_prev = 1'b0;
  bit   lights_seen = 1'b0;

  // Pop and compare on every winrnd; also enforce single-cycle pulses
  always @(negedge clk) begin
    exp_t e;
    if (state_dbg == 3'd2) lights_seen = 1'b1;
    if (winrnd_prev) begin
      n_chk++;
      if (winrnd) begin
        n_err++;
        $display("FAIL winrnd_pulse: winrnd high two cycles running at %0t", $time);
      end
    end
    if (winrnd) begin
      n_chk++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_winrnd: winrnd=1 with nothing expected at %0t", $time);
      end else begin
        e = sb.pop_front();
        if ({right, tie, leds_on, fake} !== {e.r, e.t, e.l, e.f}) begin
          n_err++;
          $display("FAIL round_result: got r/t/led/fake=%b%b%b%b expected %b%b%b%b at %0t",
                   right, tie, leds_on, fake, e.r, e.t, e.l, e.f, $time);
        end
      end
    end
    winrnd_prev = winrnd;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget);
    int n = 0;
    do begin
      step();
      n++;
    end while (state_dbg !== s && n < budget);
    check("wait_state", {29'd0, state_dbg}, {29'd0, s});
  endtask

  typedef struct {
    bit   in_delay;
    int   off;
    logic pl, pr;
    logic er, et, eled;
    bit   lights;
    bit   hpush;
    bit   gover;
  } vec_t;
  vec_t tbl[7];

  task automatic run_round(input vec_t v);
    int   cnt;
    int   d;
    logic ef;
    exp_t e;
    wait_state(3'd1, 300);
    ef = (lf_prev[7:6] == 2'b00);
    d  = MIN_D + int'(lf_prev[0]);
    check("arm_fake", {31'd0, fake}, {31'd0, ef});
    lights_seen = 1'b0;
    if (!v.in_delay) begin
      cnt = 1;
      forever begin
        step();
        if (leds_on) break;
        cnt++;
        if (cnt > 100) break;
      end
      check("delay_len", cnt, d);
    end
    repeat (v.off) step();
    e = '{v.er, v.et, v.eled, ef};
    sb.push_back(e);
    pb_l = v.pl;
    pb_r = v.pr;
    step();
    check("score_state", {29'd0, state_dbg}, 32'd3);
    pb_l = 1'b0;
    pb_r = 1'b0;
    step();
    cnt = 0;
    while (state_dbg == 3'd4 && cnt < 100) begin
      cnt++;
      if (v.hpush) begin
        pb_l = cnt[0];
        pb_r = cnt[1];
      end
      if (v.gover && cnt == 5) game_over = 1'b1;
      step();
    end
    pb_l = 1'b0;
    pb_r = 1'b0;
    check("hold_len", cnt, 32);
    check("after_hold_state", {29'd0, state_dbg}, v.gover ? 32'd5 : 32'd0);
    check("lights_visited", {31'd0, lights_seen}, {31'd0, v.lights});
    check("qual_retained", {30'd0, right, tie}, v.gover ? 32'd0 : {30'd0, v.er, v.et});
  endtask

  initial begin
    int   cnt;
    int   nwin;
    bit   left_idle;
    exp_t e;

    //              dly off pl pr er et led lit hp go
    tbl[0] = '{1'b0, 3,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 2,  1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[2] = '{1'b0, 1,  1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[3] = '{1'b0, 0,  1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[4] = '{1'b1, 0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[5] = '{1'b1, 1,  1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[6] = '{1'b0, 10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

    // Reset state
    rst = 1'b1;
    repeat (3) step();
    check("reset_outputs", {24'd0, winrnd, right, tie, leds_on, fake, state_dbg}, 32'd0);
    rst = 1'b0;

    // Timeout round: arms on SEED, whose top bits make it a fake round
    wait_state(3'd1, 5);
    check("timeout_fake", {31'd0, fake}, {31'd0, lf_prev[7:6] == 2'b00});
    wait_state(3'd2, 20);
    e = '{1'b0, 1'b1, 1'b1, 1'b1};
    sb.push_back(e);
    cnt = 0;
    while (leds_on && !winrnd && cnt < 500) begin
      cnt++;
      step();
    end
    check("lights_window", cnt, 200);
    check("timeout_winrnd", {31'd0, winrnd}, 32'd1);
    wait_state(3'd0, 100);

    // Held button keeps the controller in IDLE
    rst  = 1'b1;
    pb_l = 1'b1;
    step();
    rst = 1'b0;
    left_idle = 1'b0;
    repeat (60) begin
      step();
      if (state_dbg != 3'd0) left_idle = 1'b1;
    end
    check("held_idle", {31'd0, left_idle}, 32'd0);

    // Release, reach LIGHTS, then reset mid-round
    pb_l = 1'b0;
    wait_state(3'd2, 50);
    rst = 1'b1;
    step();
    check("rst_mid_round", {24'd0, winrnd, right, tie, leds_on, fake, state_dbg}, 32'd0);
    rst = 1'b0;

    // Table of rounds; the last one ends the game
    for (int i = 0; i < 7; i++) run_round(tbl[i]);

    // DONE absorbs pushes
    nwin = 0;
    for (int i = 0; i < 20; i++) begin
      pb_l = i[0];
      pb_r = i[1];
      step();
      if (winrnd) nwin++;
    end
    pb_l = 1'b0;
    pb_r = 1'b0;
    check("done_no_winrnd", nwin, 0);
    check("done_outputs", {24'd0, winrnd, right, tie, leds_on, fake, state_dbg}, 32'd5);

    // Only reset leaves DONE
    rst       = 1'b1;
    game_over = 1'b0;
    step();
    rst = 1'b0;
    check("done_reset", {29'd0, state_dbg}, 32'd0);
    step();
    check("rearm_after_reset", {29'd0, state_dbg}, 32'd1);
    check("scoreboard_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
